l4_fetch_ctrl: RTL and testbench
================================

# l4_fetch_ctrl

Instruction-fetch sequencer for the lab 4 processor. It drives the 8-bit word index of the combinational instruction memory and captures the returned 16-bit word into an instruction register. It presents that word to decode over a valid/ready handshake and handles start, branch redirect, halt and end-of-program. It sits between the instruction memory and the decode/execute stage and is the only master of the memory index.

## Interface
- `ADDR_W`, 8: width of the memory index.
- `INSTR_W`, 16: instruction width.
- `PROG_LEN`, 21: number of valid program words (indices 0..PROG_LEN-1); legal range 1..256.
- `HALT_OP`, 4'hF: opcode (instr[15:12]) that terminates the program.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begins execution at index 0 from IDLE or DONE.
- `count`  out  ADDR_W  index driven to instruction memory (registered).
- `mem_data`  in  INSTR_W  memory word for `count`, valid in the same cycle.
- `instr`  out  INSTR_W  instruction register.
- `instr_valid`  out  1  `instr` holds an unconsumed instruction.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `branch_en`  in  1  the instruction consumed this cycle redirects fetch.
- `branch_target`  in  ADDR_W  redirect index.
- `busy`  out  1  state is RUN or DRAIN.
- `halted`  out  1  state is DONE.
- `range_err`  out  1  sticky; a fetch was attempted at index >= PROG_LEN.

## Operation
- Reset values: state IDLE, count 0, instr 0, instr_valid 0, busy 0, halted 0, range_err 0. Assertion mid-run aborts immediately, with no drain.
- A handshake occurs when `instr_valid && instr_ready`. `instr` is stable while `instr_valid && !instr_ready`.
- IDLE: outputs held. On `start`: count <= 0, go RUN.
- RUN, fetch slot when `!instr_valid || handshake`:
  - If handshake with `branch_en`: no load; instr_valid <= 0; count <= branch_target. This gives one bubble.
  - Else if count >= PROG_LEN: no load; instr_valid <= 0; range_err <= 1; go DONE.
  - Else: instr <= mem_data; instr_valid <= 1; count <= count+1, modulo 2^ADDR_W, so PROG_LEN=256 wraps to 0. If mem_data[15:12] == HALT_OP, go DRAIN with count unchanged.
- RUN, no fetch slot: hold everything.
- DRAIN: the halt word is presented. No further fetch. `branch_en` is ignored. On handshake: instr_valid <= 0, go DONE.
- DONE: halted=1, instr_valid=0. `start` behaves as in IDLE and clears range_err.
- `start` is ignored in RUN and DRAIN.
- Simultaneous events:
  - branch_en with a handshake on a halt word is ignored, because DRAIN has priority.
  - branch_en without a handshake is ignored.
  - A branch to a target >= PROG_LEN sets range_err on the following fetch slot.

## Timing
- Memory is combinational, so `count` to `mem_data` is the same cycle. Capture occurs at the clock edge ending the fetch-slot cycle.
- Start latency: `start` at edge 0, RUN with count=0 at edge 1, instr_valid=1 with instr=word[0] at edge 2.
- With instr_ready held high, throughput is 1 instruction per cycle.
- Branch: consumed at edge n; word[target] becomes valid at edge n+2.
- Halt: the halt word is valid at edge k; with ready high, halted=1 at edge k+1.
- All outputs are registered, except busy and halted, which are decoded from the state register.

## Structure
- Package `l4_pkg`:
  - `fetch_state_t` enum {IDLE, RUN, DRAIN, DONE}.
  - `HALT_OP` default.
  - `ADDR_W`/`INSTR_W` constants.
  - `opcode()` field-extract function.
- Single module; no sub-module. The instruction memory is instantiated beside it at the top level, with its index wired to `count` and its data output wired to `mem_data`.

## Test plan
- Reset, start, ready high, program 0x1001,0x1002,0xF000: instr sequence 0x1001,0x1002,0xF000 on consecutive cycles; halted=1 one cycle after 0xF000; count frozen at 2.
- instr_ready low for 3 cycles while word[1] is valid: instr, instr_valid and count are unchanged; the sequence resumes with no loss or duplication.
- branch_en=1, target 5, on the handshake of word[1]: one bubble, next valid instr = word[5], count=6 afterward.
- Program with no halt and PROG_LEN=4: words 0..3 delivered, then range_err=1, halted=1; start then clears range_err and re-fetches word[0].
- rst_n low while in RUN with instr_valid=1: all outputs go to reset values before the next edge; start afterward restarts at index 0.
- Branch to target 30 with PROG_LEN=21: no word delivered; range_err=1, DONE on the next fetch slot.

Source files
------------

// File: rtl/l4_pkg.sv
// Shared types and constants for the lab 4 instruction-fetch sequencer.
package l4_pkg;

   localparam int         ADDR_W  = 8;
   localparam int         INSTR_W = 16;
   localparam logic [3:0] HALT_OP = 4'hF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_t;

   function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] w);
      return w[INSTR_W-1 -: 4];
   endfunction

endpackage

// File: rtl/l4_fetch_ctrl.sv
// Fetch sequencer: owns the instruction-memory index, captures words into the
// instruction register and hands them to decode over a valid/ready handshake.
module l4_fetch_ctrl #(
   parameter int         ADDR_W   = l4_pkg::ADDR_W,
   parameter int         INSTR_W  = l4_pkg::INSTR_W,
   parameter int         PROG_LEN = 21,
   parameter logic [3:0] HALT_OP  = l4_pkg::HALT_OP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [ADDR_W-1:0]  count,
   input  logic [INSTR_W-1:0] mem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               branch_en,
   input  logic [ADDR_W-1:0]  branch_target,
   output logic               busy,
   output logic               halted,
   output logic               range_err
);
   import l4_pkg::*;

   // One extra bit so PROG_LEN = 256 never compares as reached.
   localparam logic [ADDR_W:0] LP_LEN = (ADDR_W+1)'(PROG_LEN);

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_count;
   logic [INSTR_W-1:0] r_instr;
   logic               r_valid;
   logic               r_range_err;

   logic w_hs;
   logic w_slot;
   logic w_past_end;
   logic w_is_halt;

   assign w_hs       = r_valid & instr_ready;
   assign w_slot     = ~r_valid | w_hs;
   assign w_past_end = ({1'b0, r_count} >= LP_LEN);
   assign w_is_halt  = (opcode(mem_data) == HALT_OP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_instr     <= '0;
         r_valid     <= 1'b0;
         r_range_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_count     <= '0;
                  r_range_err <= 1'b0;
                  r_state     <= RUN;
               end
            end
            RUN: begin
               if (w_slot) begin
                  if (w_hs && branch_en) begin
                     r_valid <= 1'b0;
                     r_count <= branch_target;
                  end else if (w_past_end) begin
                     r_valid     <= 1'b0;
                     r_range_err <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_instr <= mem_data;
                     r_valid <= 1'b1;
                     // The halt word keeps count pointing at itself.
                     if (w_is_halt)
                        r_state <= DRAIN;
                     else
                        r_count <= r_count + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_hs) begin
                  r_valid <= 1'b0;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign count       = r_count;
   assign instr       = r_instr;
   assign instr_valid = r_valid;
   assign range_err   = r_range_err;
   assign busy        = (r_state == RUN) || (r_state == DRAIN);
   assign halted      = (r_state == DONE);

endmodule

// File: tb/tb_l4_fetch_ctrl.sv
// Bench for l4_fetch_ctrl: directed timing cases plus randomized runs scored
// against a program-counter walk over the handshakes.
module tb_l4_fetch_ctrl;

   localparam int PLEN = 21;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  count;
   logic [15:0] mem_data;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        branch_en = 1'b0;
   logic [7:0]  branch_target = '0;
   logic        busy;
   logic        halted;
   logic        range_err;

   logic [15:0] mem [256];
   int          n_checks = 0;
   int          n_errors = 0;

   assign mem_data = mem[count];

   always #5 clk = ~clk;

   l4_fetch_ctrl #(.ADDR_W(8), .INSTR_W(16), .PROG_LEN(PLEN), .HALT_OP(4'hF)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .count         (count),
      .mem_data      (mem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .busy          (busy),
      .halted        (halted),
      .range_err     (range_err)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_linear();
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_valid"}, instr_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_halted"}, halted, 0);
      chk({tag, "_rerr"}, range_err, 0);
   endtask

   // Reset into IDLE, then start; returns just after the edge that enters RUN.
   task automatic restart();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      fill_linear();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");
      rst_n = 1'b1;

      // Three-word program ending in halt, ready held high.
      mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'hF000;
      instr_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("st_busy", busy, 1);
      chk("st_count", count, 0);
      chk("st_valid", instr_valid, 0);
      tick();
      chk("p_w0", instr, 16'h1001);
      chk("p_v0", instr_valid, 1);
      chk("p_c0", count, 1);
      tick();
      chk("p_w1", instr, 16'h1002);
      tick();
      chk("p_w2", instr, 16'hF000);
      chk("p_c2", count, 2);
      chk("p_nothalt", halted, 0);
      tick();
      chk("p_halted", halted, 1);
      chk("p_valid_off", instr_valid, 0);
      chk("p_busy_off", busy, 0);
      chk("p_count_frozen", count, 2);

      // Stall for three cycles on word[1], then resume.
      fill_linear();
      restart();
      instr_ready = 1'b1;
      tick();
      tick();
      chk("stl_w1", instr, 16'h1001);
      instr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stl_hold_instr", instr, 16'h1001);
         chk("stl_hold_valid", instr_valid, 1);
         chk("stl_hold_count", count, 2);
      end
      instr_ready = 1'b1;
      tick();
      chk("stl_resume", instr, 16'h1002);
      tick();
      chk("stl_next", instr, 16'h1003);

      // Branch to 5 on the handshake of word[1].
      restart();
      tick();
      tick();
      chk("br_w1", instr, 16'h1001);
      branch_en = 1'b1;
      branch_target = 8'd5;
      tick();
      branch_en = 1'b0;
      chk("br_bubble", instr_valid, 0);
      chk("br_count_tgt", count, 5);
      tick();
      chk("br_valid", instr_valid, 1);
      chk("br_word", instr, 16'h1005);
      chk("br_count", count, 6);

      // No halt: words 0..PLEN-1, then range error and DONE; start clears it.
      restart();
      for (int i = 0; i < PLEN; i++) begin
         tick();
         chk("rng_word", instr, 16'h1000 | 16'(i));
      end
      tick();
      chk("rng_err", range_err, 1);
      chk("rng_halted", halted, 1);
      chk("rng_valid", instr_valid, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rng_clear", range_err, 0);
      chk("rng_busy", busy, 1);
      tick();
      chk("rng_refetch", instr, 16'h1000);

      // Asynchronous reset mid-run, then restart.
      restart();
      tick();
      tick();
      chk("ar_pre_valid", instr_valid, 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("ar");
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("ar_restart", instr, 16'h1000);

      // Branch beyond the program.
      restart();
      tick();
      branch_en = 1'b1;
      branch_target = 8'd30;
      tick();
      branch_en = 1'b0;
      chk("bo_valid", instr_valid, 0);
      chk("bo_count", count, 30);
      chk("bo_noerr_yet", range_err, 0);
      tick();
      chk("bo_err", range_err, 1);
      chk("bo_halted", halted, 1);
      chk("bo_valid2", instr_valid, 0);

      // Randomized runs scored against a walk over the handshakes.
      for (int ep = 0; ep < 25; ep++) begin
         int  pc;
         int  nbr;
         int  cyc;
         bit  halt_hit;
         bit  hs;
         for (int i = 0; i < 256; i++) begin
            mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
         end
         if ($urandom_range(0, 1) == 1) mem[$urandom_range(2, PLEN-1)][15:12] = 4'hF;
         restart();
         pc = 0; nbr = 0; cyc = 0; halt_hit = 1'b0;
         while (!halted && cyc < 600) begin
            if (instr_valid) begin
               if (pc >= PLEN) begin
                  chk("rnd_oob_valid", 1, 0);
               end else begin
                  chk("rnd_instr", instr, mem[pc]);
                  chk("rnd_count", count, (mem[pc][15:12] == 4'hF) ? pc : pc + 1);
               end
            end
            instr_ready   = ($urandom_range(0, 3) != 0);
            branch_en     = (nbr < 4) && ($urandom_range(0, 4) == 0);
            branch_target = 8'($urandom_range(0, 31));
            start         = ($urandom_range(0, 19) == 0);
            hs = instr_valid && instr_ready;
            tick();
            start = 1'b0;
            cyc++;
            if (hs && pc < PLEN) begin
               if (mem[pc][15:12] == 4'hF) begin
                  halt_hit = 1'b1;
                  chk("rnd_halt_done", halted, 1);
               end else if (branch_en) begin
                  pc = branch_target;
                  nbr++;
               end else begin
                  pc++;
               end
            end
         end
         branch_en = 1'b0;
         chk("rnd_end_halted", halted, 1);
         chk("rnd_end_expected", (halt_hit || pc >= PLEN), 1);
         chk("rnd_end_rerr", range_err, !halt_hit);
         chk("rnd_end_count", count, pc);
         chk("rnd_end_valid", instr_valid, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
